// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared types and constants for the divider arbiter.
//   state_t   : arbiter FSM states
//   ERR_*     : response error codes carried on rsp_err_o
//   clog2     : ceiling log2 (minimum 1) used to size id and counter fields
package div_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

  // Ceiling log2, never below 1 so that a field is always at least one bit wide.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 <<< r) < value) begin
        r = r + 1;
      end else begin
        r = r;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : index of the last winner; the search starts just after it
//   id    : index of the first set request after ptr (wrapping)
//   valid : high when any request is set
module rr_arbiter
  import div_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  int   idx;
  logic hit;

  // Walk from the farthest candidate back to the nearest so the nearest set
  // bit after ptr is the last one written and therefore wins.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    idx   = 0;
    hit   = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx   = (int'(ptr) + i) % N_REQ;
      hit   = req[idx];
      id    = hit ? idx[ID_W-1:0] : id;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one sequential divider among N_REQ requesters.
//   clk_i_arb, rstn_i_arb : clock, asynchronous active-low reset
//   req_i_arb             : per-requester request levels
//   divisor_i, dividend_i : packed operands, requester k at slice k
//   gnt_o                 : one-hot, one-cycle accept pulse
//   rsp_valid_o, rsp_id_o, rsp_result_o, rsp_err_o : tagged response
//   busy_o                : high whenever the FSM is not idle
//   div_en_o, div_b_o, div_q_o, div_result_i, div_done_i : divider handshake
// Divide-by-zero and quotient overflow are screened before the divider is
// started; a hung divider is cut off after TIMEOUT_CYCLES cycles in WAIT.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i_arb,
  input  logic                          rstn_i_arb,
  input  logic [N_REQ-1:0]              req_i_arb,
  input  logic [N_REQ*DATA_WIDTH-1:0]   divisor_i,
  input  logic [N_REQ*2*DATA_WIDTH-1:0] dividend_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic                          rsp_valid_o,
  output logic [clog2(N_REQ)-1:0]       rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_result_o,
  output logic [1:0]                    rsp_err_o,
  output logic                          busy_o,
  output logic                          div_en_o,
  output logic [DATA_WIDTH-1:0]         div_b_o,
  output logic [2*DATA_WIDTH-1:0]       div_q_o,
  input  logic [DATA_WIDTH-1:0]         div_result_i,
  input  logic                          div_done_i
);

  localparam int ID_W  = clog2(N_REQ);
  localparam int CNT_W = clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t                  state_r, next_state;
  logic [ID_W-1:0]         ptr_r, cap_id_r;
  logic [DATA_WIDTH-1:0]   cap_div_r;
  logic [2*DATA_WIDTH-1:0] cap_dvd_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [N_REQ-1:0]        gnt_r;
  logic                    rsp_valid_r, div_en_r, busy_r;
  logic [ID_W-1:0]         rsp_id_r;
  logic [DATA_WIDTH-1:0]   rsp_result_r;
  logic [1:0]              rsp_err_r;

  logic [ID_W-1:0]         pick_id;
  logic                    pick_valid;
  logic [DATA_WIDTH-1:0]   sel_div;
  logic [2*DATA_WIDTH-1:0] sel_dvd;
  logic [1:0]              scr_err;
  logic                    timeout_hit;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req   (req_i_arb),
    .ptr   (ptr_r),
    .id    (pick_id),
    .valid (pick_valid)
  );

  assign sel_div     = divisor_i[pick_id*DATA_WIDTH +: DATA_WIDTH];
  assign sel_dvd     = dividend_i[pick_id*2*DATA_WIDTH +: 2*DATA_WIDTH];
  assign timeout_hit = (cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge clk_i_arb or negedge rstn_i_arb) begin
    if (!rstn_i_arb) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state;
    end
  end

  // Next-state logic and operand screening; div-by-zero outranks overflow.
  always_comb begin
    next_state = state_r;
    scr_err    = ERR_OK;
    case (state_r)
      ST_IDLE: begin
        if (!pick_valid) begin
          next_state = ST_IDLE;
        end else if (sel_div == {DATA_WIDTH{1'b0}}) begin
          next_state = ST_RESP;
          scr_err    = ERR_DIV0;
        end else if (sel_dvd[2*DATA_WIDTH-1:DATA_WIDTH] >= sel_div) begin
          next_state = ST_RESP;
          scr_err    = ERR_OVF;
        end else begin
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (div_done_i || timeout_hit) begin
          next_state = ST_RESP;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Capture, timeout counter and response registers. gnt and rsp_valid are
  // pulses, cleared every cycle unless set below.
  always_ff @(posedge clk_i_arb or negedge rstn_i_arb) begin
    if (!rstn_i_arb) begin
      ptr_r        <= ID_W'(N_REQ - 1);
      cap_id_r     <= '0;
      cap_div_r    <= '0;
      cap_dvd_r    <= '0;
      cnt_r        <= '0;
      gnt_r        <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_result_r <= '0;
      rsp_err_r    <= ERR_OK;
    end else begin
      gnt_r       <= '0;
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid) begin
            cap_id_r  <= pick_id;
            cap_div_r <= sel_div;
            cap_dvd_r <= sel_dvd;
            ptr_r     <= pick_id;
            gnt_r     <= ONE_HOT0 << pick_id;
            if (next_state == ST_RESP) begin
              // Screened error: the response coincides with the grant.
              rsp_valid_r  <= 1'b1;
              rsp_id_r     <= pick_id;
              rsp_err_r    <= scr_err;
              rsp_result_r <= (scr_err == ERR_DIV0) ? {DATA_WIDTH{1'b1}}
                                                    : {DATA_WIDTH{1'b0}};
            end
          end
        end
        ST_ISSUE: cnt_r <= '0;
        ST_WAIT: begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (div_done_i) begin
            rsp_valid_r  <= 1'b1;
            rsp_id_r     <= cap_id_r;
            rsp_result_r <= div_result_i;
            rsp_err_r    <= ERR_OK;
          end else if (timeout_hit) begin
            rsp_valid_r  <= 1'b1;
            rsp_id_r     <= cap_id_r;
            rsp_result_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r    <= ERR_TMO;
          end
        end
        ST_RESP: cnt_r <= cnt_r;
        default: cnt_r <= '0;
      endcase
    end
  end

  // Divider enable and busy follow the state being entered, so they are
  // registered yet line up exactly with ISSUE/WAIT and non-IDLE.
  always_ff @(posedge clk_i_arb or negedge rstn_i_arb) begin
    if (!rstn_i_arb) begin
      div_en_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      div_en_r <= (next_state == ST_ISSUE) || (next_state == ST_WAIT);
      busy_r   <= (next_state != ST_IDLE);
    end
  end

  assign gnt_o        = gnt_r;
  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_id_o     = rsp_id_r;
  assign rsp_result_o = rsp_result_r;
  assign rsp_err_o    = rsp_err_r;
  assign busy_o       = busy_r;
  assign div_en_o     = div_en_r;
  assign div_b_o      = cap_div_r;
  assign div_q_o      = cap_dvd_r;

endmodule
